// File: rtl/gci_std_display_bar_writer.sv
// ----------------------------------------------------------------------------
// gci_std_display_bar_writer
//
// Colour-bar VRAM filler. It sits on the write bus in front of gci_std_display.
// A start pulse makes it write every pixel of the frame buffer once, in raster
// order. Each pixel gets a 16-bit RGB565 colour-bar value. It is used for
// power-on test screens and for self-checking display simulation.
//
// Parameters
//   P_H_SIZE     pixels per line (<= 1024)
//   P_V_SIZE     lines per frame (<= 512)
//   P_BASE_ADDR  bus address of pixel 0
//
// Ports
//   iCLOCK     in   system clock, rising edge
//   inRESET    in   synchronous active-low reset
//   iSTART     in   single-cycle start request (honoured only when idle)
//   iABORT     in   finish the in-flight request, then stop
//   oBUSY      out  high from the cycle after start up to and including DONE
//   oDONE      out  one-cycle pulse when the frame or the abort completes
//   oDEV_REQ   out  bus write request
//   iDEV_BUSY  in   display busy; stalls the pending request
//   oDEV_RW    out  1 = write (mirrors oDEV_REQ)
//   oDEV_ADDR  out  write address, P_BASE_ADDR + 4*pixel_index
//   oDEV_DATA  out  write data, {16'h0, RGB565}
//
// Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module gci_std_display_bar_writer #(
   parameter int          P_H_SIZE    = 640,
   parameter int          P_V_SIZE    = 480,
   parameter logic [31:0] P_BASE_ADDR = 32'h0000C400
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iSTART,
   input  logic        iABORT,
   output logic        oBUSY,
   output logic        oDONE,
   output logic        oDEV_REQ,
   input  logic        iDEV_BUSY,
   output logic        oDEV_RW,
   output logic [31:0] oDEV_ADDR,
   output logic [31:0] oDEV_DATA
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [9:0] H_LAST = 10'(P_H_SIZE - 1);
   localparam logic [8:0] V_LAST = 9'(P_V_SIZE - 1);

   // Horizontal band: the screen is cut into 80-pixel columns (5 steps of
   // h[9:4]). Everything from column 7 onward shares the last band.
   function automatic logic [2:0] h_band(input logic [9:0] h);
      logic [5:0] hb;
      hb = h[9:4];
      if      (hb < 6'd5)  h_band = 3'd0;
      else if (hb < 6'd10) h_band = 3'd1;
      else if (hb < 6'd15) h_band = 3'd2;
      else if (hb < 6'd20) h_band = 3'd3;
      else if (hb < 6'd25) h_band = 3'd4;
      else if (hb < 6'd30) h_band = 3'd5;
      else if (hb < 6'd35) h_band = 3'd6;
      else                 h_band = 3'd7;
   endfunction

   // Vertical band: 120-line rows. Row 3 runs to the bottom of the frame.
   function automatic logic [1:0] v_band(input logic [8:0] v);
      if      (v < 9'd120) v_band = 2'd0;
      else if (v < 9'd240) v_band = 2'd1;
      else if (v < 9'd360) v_band = 2'd2;
      else                 v_band = 2'd3;
   endfunction

   // The bands are summed with 3-bit wrap so that the colours rotate by one
   // step on each row band.
   function automatic logic [15:0] bar_colour(input logic [9:0] h, input logic [8:0] v);
      logic [2:0] sel;
      sel = h_band(h) + {1'b0, v_band(v)};
      case (sel)
         3'd0:    bar_colour = 16'hF800;
         3'd1:    bar_colour = 16'h07E0;
         3'd2:    bar_colour = 16'h001F;
         3'd3:    bar_colour = 16'hF81F;
         3'd4:    bar_colour = 16'hFFE0;
         3'd5:    bar_colour = 16'h07FF;
         3'd6:    bar_colour = 16'h0000;
         default: bar_colour = 16'hFFFF;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        abort_q, abort_d;
   logic [9:0]  h_q,     h_d;
   logic [8:0]  v_q,     v_d;
   logic [19:0] idx_q,   idx_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;
   logic        req_q,   req_d;
   logic [31:0] addr_q,  addr_d;
   logic [15:0] data_q,  data_d;

   logic accept;
   logic last_pixel;

   assign accept     = req_q && !iDEV_BUSY;
   assign last_pixel = (h_q == H_LAST) && (v_q == V_LAST);

   always_comb begin
      state_d = state_q;
      abort_d = abort_q;
      h_d     = h_q;
      v_d     = v_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      req_d   = req_q;
      addr_d  = addr_q;
      data_d  = data_q;

      case (state_q)
         ST_IDLE: begin
            // An abort while idle (even one alongside start) is dropped.
            abort_d = 1'b0;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            if (iSTART) begin
               state_d = ST_REQ;
               h_d     = '0;
               v_d     = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               req_d   = 1'b1;
               addr_d  = P_BASE_ADDR;
               data_d  = bar_colour(10'd0, 9'd0);
            end
         end

         ST_REQ: begin
            if (iABORT) abort_d = 1'b1;
            if (accept) begin
               req_d = 1'b0;
               // An abort in the same cycle as acceptance still counts, so
               // the write being accepted is the last one.
               if (last_pixel || abort_q || iABORT) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  idx_d   = idx_q + 20'd1;
                  if (h_q == H_LAST) begin
                     h_d = '0;
                     v_d = v_q + 9'd1;
                  end else begin
                     h_d = h_q + 10'd1;
                  end
               end
            end
            // When not accepted, addr/data stay put for the stalled request.
         end

         ST_GAP: begin
            if (iABORT) abort_d = 1'b1;
            // Address and colour are loaded only here, when REQ is entered.
            // That keeps them stable for as long as the display stalls.
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = P_BASE_ADDR + {10'd0, idx_q, 2'b00};
            data_d  = bar_colour(h_q, v_q);
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
            busy_d  = 1'b0;
            addr_d  = '0;
            data_d  = '0;
         end

         default: begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            addr_d  = '0;
            data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         state_q <= ST_IDLE;
         abort_q <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         abort_q <= abort_d;
         h_q     <= h_d;
         v_q     <= v_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign oBUSY     = busy_q;
   assign oDONE     = done_q;
   assign oDEV_REQ  = req_q;
   assign oDEV_RW   = req_q;
   assign oDEV_ADDR = addr_q;
   assign oDEV_DATA = {16'h0000, data_q};

endmodule

// File: tb/tb_gci_std_display_bar_writer.sv
// Bench for gci_std_display_bar_writer. Two instances are used so that full
// fills stay short: A is 640x4, which covers every horizontal band. B is
// 8x480, which covers every vertical band.
module tb_gci_std_display_bar_writer;

   localparam logic [31:0] BASE = 32'h0000C400;
   localparam int AH = 640, AV = 4,   AN = AH * AV;
   localparam int BH = 8,   BV = 480, BN = BH * BV;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst_n, a_start, a_abort, a_busy_in;
   logic        a_busy, a_done, a_req, a_rw;
   logic [31:0] a_addr, a_data;
   logic        b_rst_n, b_start, b_abort, b_busy_in;
   logic        b_busy, b_done, b_req, b_rw;
   logic [31:0] b_addr, b_data;

   gci_std_display_bar_writer #(.P_H_SIZE(AH), .P_V_SIZE(AV), .P_BASE_ADDR(BASE)) dut_a (
      .iCLOCK(clk), .inRESET(a_rst_n), .iSTART(a_start), .iABORT(a_abort),
      .oBUSY(a_busy), .oDONE(a_done), .oDEV_REQ(a_req), .iDEV_BUSY(a_busy_in),
      .oDEV_RW(a_rw), .oDEV_ADDR(a_addr), .oDEV_DATA(a_data));

   gci_std_display_bar_writer #(.P_H_SIZE(BH), .P_V_SIZE(BV), .P_BASE_ADDR(BASE)) dut_b (
      .iCLOCK(clk), .inRESET(b_rst_n), .iSTART(b_start), .iABORT(b_abort),
      .oBUSY(b_busy), .oDONE(b_done), .oDEV_REQ(b_req), .iDEV_BUSY(b_busy_in),
      .oDEV_RW(b_rw), .oDEV_ADDR(b_addr), .oDEV_DATA(b_data));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference colour: the bands are 80 pixels wide and 120 lines tall.
   function automatic logic [15:0] model_colour(input int h, input int v);
      int hc, vc;
      hc = h / 80; if (hc > 7) hc = 7;
      vc = v / 120; if (vc > 3) vc = 3;
      case ((hc + vc) % 8)
         0: return 16'hF800;
         1: return 16'h07E0;
         2: return 16'h001F;
         3: return 16'hF81F;
         4: return 16'hFFE0;
         5: return 16'h07FF;
         6: return 16'h0000;
         default: return 16'hFFFF;
      endcase
   endfunction

   function automatic logic [31:0] a_outs();
      return {26'd0, a_busy, a_done, a_req, a_rw, |a_addr, |a_data};
   endfunction

   // Bus models: a write is captured at the negedge before the accepting edge.
   logic [31:0] a_cap_addr [4096];
   logic [31:0] a_cap_data [4096];
   logic [31:0] b_cap_addr [4096];
   logic [31:0] b_cap_data [4096];
   int a_wr = 0, a_base = 0, b_wr = 0;
   logic a_stalled = 1'b0;
   logic [31:0] a_hold_addr, a_hold_data;

   always @(negedge clk) begin
      if (a_rst_n) check("rw_follows_req", {31'd0, a_rw}, {31'd0, a_req});
      if (a_req) begin
         if (a_stalled) begin
            check("stall_addr_stable", a_addr, a_hold_addr);
            check("stall_data_stable", a_data, a_hold_data);
         end
         if (!a_busy_in) begin
            if (a_wr - a_base >= 0 && a_wr - a_base < 4096) begin
               a_cap_addr[a_wr - a_base] = a_addr;
               a_cap_data[a_wr - a_base] = a_data;
            end
            a_wr++;
         end
      end
      a_stalled   = a_req && a_busy_in;
      a_hold_addr = a_addr;
      a_hold_data = a_data;
   end

   always @(negedge clk) begin
      if (b_req && !b_busy_in) begin
         if (b_wr < 4096) begin
            b_cap_addr[b_wr] = b_addr;
            b_cap_data[b_wr] = b_data;
         end
         b_wr++;
      end
   end

   task automatic a_start_pulse(input logic with_abort);
      @(posedge clk); #1;
      a_start = 1'b1; a_abort = with_abort;
      @(posedge clk); #1;
      a_start = 1'b0; a_abort = 1'b0;
   endtask

   // Counts cycles (first negedge = first cycle after the last edge) until
   // oDONE is seen, returning -1 if the limit runs out.
   task automatic a_wait_done(input logic rnd, input int limit, output int k);
      k = 0;
      forever begin
         @(negedge clk); k++;
         if (a_done) break;
         if (k >= limit) begin k = -1; break; end
         @(posedge clk); #1;
         if (rnd) a_busy_in = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic verify_a(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         check({tag, "_addr"}, a_cap_addr[k], BASE + 32'(k * 4));
         check({tag, "_data"}, a_cap_data[k], {16'h0, model_colour(k % AH, k / AH)});
      end
   endtask

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic [15:0] data;
   } vec_t;

   vec_t a_vec [12];
   vec_t b_vec [6];

   initial begin
      int k;
      int found;

      a_vec[0]  = '{0,    32'h0000C400, 16'hF800};
      a_vec[1]  = '{79,   32'h0000C53C, 16'hF800};
      a_vec[2]  = '{80,   32'h0000C540, 16'h07E0};
      a_vec[3]  = '{160,  32'h0000C680, 16'h001F};
      a_vec[4]  = '{240,  32'h0000C7C0, 16'hF81F};
      a_vec[5]  = '{320,  32'h0000C900, 16'hFFE0};
      a_vec[6]  = '{400,  32'h0000CA40, 16'h07FF};
      a_vec[7]  = '{559,  32'h0000CCBC, 16'h0000};
      a_vec[8]  = '{560,  32'h0000CCC0, 16'hFFFF};
      a_vec[9]  = '{639,  32'h0000CDFC, 16'hFFFF};
      a_vec[10] = '{640,  32'h0000CE00, 16'hF800};
      a_vec[11] = '{2559, 32'h0000EBFC, 16'hFFFF};
      b_vec[0]  = '{0,    32'h0000C400, 16'hF800};
      b_vec[1]  = '{952,  32'h0000D2E0, 16'hF800};
      b_vec[2]  = '{960,  32'h0000D300, 16'h07E0};
      b_vec[3]  = '{1920, 32'h0000E200, 16'h001F};
      b_vec[4]  = '{2880, 32'h0000F100, 16'hF81F};
      b_vec[5]  = '{3839, 32'h0000FFFC, 16'hF81F};

      a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_busy_in = 1'b0;
      b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_busy_in = 1'b0;

      // Reset, then a quiet idle period with stray abort pulses.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", a_outs(), 32'd0);
      @(posedge clk); #1;
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         a_abort = (c % 10 == 3);
         @(negedge clk);
         check("idle_quiet", a_outs(), 32'd0);
         @(posedge clk); #1;
      end
      a_abort = 1'b0;

      // Full fill, display never busy.
      a_base = a_wr;
      a_start_pulse(1'b0);
      a_wait_done(1'b0, 3 * AN, k);
      check("fill_done_cycle", 32'(k), 32'(2 * AN));
      check("busy_in_done_cycle", {31'd0, a_busy}, 32'd1);
      @(negedge clk);
      check("idle_after_fill", a_outs(), 32'd0);
      check("fill_write_count", 32'(a_wr - a_base), 32'(AN));
      for (int i = 0; i < 12; i++) begin
         check($sformatf("vec_a_addr_%0d", a_vec[i].idx), a_cap_addr[a_vec[i].idx], a_vec[i].addr);
         check($sformatf("vec_a_data_%0d", a_vec[i].idx), a_cap_data[a_vec[i].idx], {16'h0, a_vec[i].data});
      end
      verify_a("fill", AN);

      // Full fill with the display randomly busy.
      a_base = a_wr;
      a_start_pulse(1'b0);
      a_wait_done(1'b1, 8 * AN, k);
      a_busy_in = 1'b0;
      check("busy_fill_finished", {31'd0, k > 0}, 32'd1);
      @(negedge clk);
      check("idle_after_busy_fill", a_outs(), 32'd0);
      check("busy_fill_write_count", 32'(a_wr - a_base), 32'(AN));
      verify_a("busy_fill", AN);

      // Abort raised in the GAP after pixel 1000: pixel 1001 still goes out.
      a_base = a_wr;
      a_start_pulse(1'b0);
      found = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (a_req && !a_busy_in && a_addr == BASE + 32'd4000) begin found = 1; break; end
      end
      check("abort_pixel1000_seen", 32'(found), 32'd1);
      @(posedge clk); #1;
      a_abort = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
      a_wait_done(1'b0, 100, k);
      check("abort_done_cycle", 32'(k), 32'd2);
      @(negedge clk);
      check("idle_after_abort", a_outs(), 32'd0);
      check("abort_write_count", 32'(a_wr - a_base), 32'd1002);
      check("abort_last_addr", a_cap_addr[1001], 32'h0000D3A4);
      check("abort_last_data", a_cap_data[1001], 32'h0000FFE0);

      // Restart into a stalled request, then reset in the middle of it.
      a_busy_in = 1'b1;
      a_start_pulse(1'b0);
      @(negedge clk);
      check("restart_first_req", {31'd0, a_req}, 32'd1);
      check("restart_busy", {31'd0, a_busy}, 32'd1);
      check("restart_addr", a_addr, 32'h0000C400);
      check("restart_data", a_data, 32'h0000F800);
      @(posedge clk); #1;
      @(negedge clk);
      check("stalled_req_held", {31'd0, a_req}, 32'd1);
      @(posedge clk); #1;
      a_rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reset_drops_req", a_outs(), 32'd0);
      @(posedge clk); #1;
      a_rst_n = 1'b1;
      a_busy_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("no_done_after_reset", a_outs(), 32'd0);
      end

      // Start together with abort in IDLE, plus a stray start mid-fill.
      a_base = a_wr;
      a_start_pulse(1'b1);
      repeat (20) @(posedge clk);
      #1 a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      a_wait_done(1'b0, 3 * AN, k);
      check("start_abort_done_cycle", 32'(21 + k), 32'(2 * AN));
      @(negedge clk);
      check("idle_after_start_abort", a_outs(), 32'd0);
      check("start_abort_write_count", 32'(a_wr - a_base), 32'(AN));
      verify_a("start_abort_fill", AN);

      // Tall narrow frame: every vertical band and the bottom line.
      @(posedge clk); #1;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      k = 0;
      forever begin
         @(negedge clk); k++;
         if (b_done) break;
         if (k >= 3 * BN) begin k = -1; break; end
      end
      check("b_done_cycle", 32'(k), 32'(2 * BN));
      @(negedge clk);
      check("b_write_count", 32'(b_wr), 32'(BN));
      check("b_idle_after", {30'd0, b_busy, b_req}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("vec_b_addr_%0d", b_vec[i].idx), b_cap_addr[b_vec[i].idx], b_vec[i].addr);
         check($sformatf("vec_b_data_%0d", b_vec[i].idx), b_cap_data[b_vec[i].idx], {16'h0, b_vec[i].data});
      end
      for (int i = 0; i < BN; i++) begin
         check("b_fill_addr", b_cap_addr[i], BASE + 32'(i * 4));
         check("b_fill_data", b_cap_data[i], {16'h0, model_colour(i % BH, i / BH)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
